// File: rtl/logic_unit_pipe.sv
// Registered eight-function bitwise logic unit with accumulator feedback and saturating op counter.
// Latency: one cycle from accept to out_s/out_valid; up to two results held (main + skid).
// Backpressure: in_ready = ~skid_valid, a pure register output with no combinational path from out_ready.
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             acc_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] main_dat;
   logic [WIDTH-1:0] skid_dat;
   logic             main_vld;
   logic             skid_vld;
   logic             accept;
   logic             main_free;

   assign in_ready  = ~skid_vld;
   assign accept    = in_valid & ~skid_vld;
   assign main_free = ~main_vld | out_ready;
   assign out_valid = main_vld;
   assign out_s     = main_dat;

   // Clear takes priority so a clear+accumulate op starts the chain from zero.
   always_comb begin
      opa = in_a;
      if (acc_clear)
         opa = '0;
      else if (acc_mode)
         opa = acc;
   end

   always_comb begin
      res = '0;
      case (op)
         3'd0: res = ~opa;
         3'd1: res = ~in_b;
         3'd2: res = opa | in_b;
         3'd3: res = ~(opa | in_b);
         3'd4: res = opa & in_b;
         3'd5: res = ~(opa & in_b);
         3'd6: res = opa ^ in_b;
         3'd7: res = ~(opa ^ in_b);
         default: res = '0;
      endcase
   end

   // Data registers only load on a real accept, so X operands while idle never reach state.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_vld <= 1'b0;
         main_dat <= '0;
         skid_vld <= 1'b0;
         skid_dat <= '0;
      end else if (main_free) begin
         if (skid_vld) begin
            main_vld <= 1'b1;
            main_dat <= skid_dat;
            skid_vld <= accept;
            if (accept)
               skid_dat <= res;
         end else begin
            main_vld <= accept;
            if (accept)
               main_dat <= res;
         end
      end else if (accept) begin
         skid_vld <= 1'b1;
         skid_dat <= res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (accept && acc_mode)
         acc <= res;
      else if (acc_clear)
         acc <= '0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         op_count <= '0;
      else if (accept && (op_count != CNT_MAX))
         op_count <= op_count + CNT_ONE;
   end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe; a second CNT_W=3 instance covers counter saturation.
module tb_logic_unit_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [2:0] op;
   logic       acc_mode;
   logic       acc_clear;
   logic       out_ready;

   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_s;
   logic [7:0] acc;
   logic [7:0] op_count;

   logic       s_in_ready;
   logic       s_out_valid;
   logic [7:0] s_out_s;
   logic [7:0] s_acc;
   logic [2:0] s_op_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .op(op), .acc_mode(acc_mode), .acc_clear(acc_clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .acc(acc),
      .op_count(op_count)
   );

   logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_a(in_a), .in_b(in_b), .op(op), .acc_mode(acc_mode), .acc_clear(acc_clear),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_s(s_out_s), .acc(s_acc),
      .op_count(s_op_count)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hA5; op = 3'd2;
      acc_mode = 1'b1; acc_clear = 1'b0; out_ready = 1'b0;
      cyc(); cyc();
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_s !== 8'h00) begin errors++; $display("FAIL reset_out_s got %h exp 00", out_s); end
      checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc got %h exp 00", acc); end
      checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got %0d exp 0", op_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_sweep();
      logic [7:0] exp_tab [8];
      exp_tab[0] = 8'h0F; exp_tab[1] = 8'h33; exp_tab[2] = 8'hFC; exp_tab[3] = 8'h03;
      exp_tab[4] = 8'hC0; exp_tab[5] = 8'h3F; exp_tab[6] = 8'h3C; exp_tab[7] = 8'hC3;
      out_ready = 1'b1; acc_mode = 1'b0; acc_clear = 1'b0;
      in_a = 8'hF0; in_b = 8'hCC; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         cyc();
         checks++;
         if (out_valid !== 1'b1 || out_s !== exp_tab[i] || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_op%0d got v=%b s=%h rdy=%b exp v=1 s=%h rdy=1", i, out_valid, out_s, in_ready, exp_tab[i]);
         end
      end
      in_valid = 1'b0; in_a = 'x; in_b = 'x;
      cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain got v=%b exp 0", out_valid); end
      checks++; if (op_count !== 8'd8) begin errors++; $display("FAIL sweep_count got %0d exp 8", op_count); end
      cyc();
      checks++; if (acc !== 8'h00 || out_s !== 8'hC3) begin errors++; $display("FAIL idle_x got acc=%h s=%h exp acc=00 s=C3", acc, out_s); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; op = 3'd4; in_valid = 1'b1;
      in_a = 8'hAA; in_b = 8'h0F;
      cyc();
      checks++; if (in_ready !== 1'b1 || out_s !== 8'h0A) begin errors++; $display("FAIL bp_first got rdy=%b s=%h exp rdy=1 s=0A", in_ready, out_s); end
      in_a = 8'h55; in_b = 8'hFF;
      cyc();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %b exp 0", in_ready); end
      in_a = 8'hFF; in_b = 8'hF0;
      cyc();
      checks++; if (in_ready !== 1'b0 || out_s !== 8'h0A || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got rdy=%b v=%b s=%h exp rdy=0 v=1 s=0A", in_ready, out_valid, out_s); end
      checks++; if (op_count !== 8'd10) begin errors++; $display("FAIL bp_no_third_accept got %0d exp 10", op_count); end
      out_ready = 1'b1;
      cyc();
      checks++; if (out_valid !== 1'b1 || out_s !== 8'h55 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got v=%b s=%h rdy=%b exp v=1 s=55 rdy=1", out_valid, out_s, in_ready); end
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_s !== 8'hF0) begin errors++; $display("FAIL bp_third got v=%b s=%h exp v=1 s=F0", out_valid, out_s); end
      checks++; if (op_count !== 8'd11) begin errors++; $display("FAIL bp_count got %0d exp 11", op_count); end
      cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%b exp 0", out_valid); end
   endtask

   task automatic test_acc_chain();
      logic [7:0] bs   [4];
      logic [7:0] exps [4];
      bs[0] = 8'h01; bs[1] = 8'h02; bs[2] = 8'h04; bs[3] = 8'h08;
      exps[0] = 8'h01; exps[1] = 8'h03; exps[2] = 8'h07; exps[3] = 8'h0F;
      out_ready = 1'b1; in_a = 8'hAA; acc_mode = 1'b1; op = 3'd2; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         acc_clear = (i == 0);
         in_b = bs[i];
         cyc();
         checks++;
         if (acc !== exps[i] || out_s !== exps[i]) begin
            errors++;
            $display("FAIL acc_or%0d got acc=%h s=%h exp %h", i, acc, out_s, exps[i]);
         end
      end
      op = 3'd6; in_b = 8'hFF;
      cyc();
      in_valid = 1'b0;
      checks++; if (acc !== 8'hF0 || out_s !== 8'hF0) begin errors++; $display("FAIL acc_xor got acc=%h s=%h exp F0", acc, out_s); end
   endtask

   task automatic test_clear_idle();
      out_ready = 1'b0; acc_clear = 1'b1; acc_mode = 1'b0; in_a = 'x; in_b = 'x;
      cyc();
      acc_clear = 1'b0;
      checks++; if (acc !== 8'h00) begin errors++; $display("FAIL clear_acc got %h exp 00", acc); end
      checks++; if (out_valid !== 1'b1 || out_s !== 8'hF0) begin errors++; $display("FAIL clear_out got v=%b s=%h exp v=1 s=F0", out_valid, out_s); end
      out_ready = 1'b1; in_valid = 1'b1; op = 3'd2; in_a = 8'h11; in_b = 8'h22;
      cyc();
      in_valid = 1'b0;
      checks++; if (out_s !== 8'h33 || acc !== 8'h00) begin errors++; $display("FAIL nonacc_op got s=%h acc=%h exp s=33 acc=00", out_s, acc); end
      cyc();
   endtask

   task automatic test_saturation();
      rst = 1'b1;
      cyc();
      rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; op = 3'd6; in_a = 8'h01; in_b = 8'h02;
      for (int i = 0; i < 10; i++) begin
         cyc();
         checks++;
         if (s_op_count !== 3'((i + 1 > 7) ? 7 : i + 1) || op_count !== 8'(i + 1)) begin
            errors++;
            $display("FAIL sat_%0d got sat=%0d cnt=%0d exp sat=%0d cnt=%0d", i, s_op_count, op_count, (i + 1 > 7) ? 7 : i + 1, i + 1);
         end
      end
      in_valid = 1'b0;
      cyc();
      checks++; if (s_op_count !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d exp 7", s_op_count); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1;
      acc_mode = 1'b1; op = 3'd1; in_b = 8'hF0; in_a = 8'h00;
      cyc();
      acc_mode = 1'b0; op = 3'd2; in_a = 8'h12; in_b = 8'h34;
      cyc();
      checks++; if (in_ready !== 1'b0 || acc !== 8'h0F || out_s !== 8'h0F) begin errors++; $display("FAIL mid_pending got rdy=%b acc=%h s=%h exp rdy=0 acc=0F s=0F", in_ready, acc, out_s); end
      rst = 1'b1; out_ready = 1'b1;
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || acc !== 8'h00 || op_count !== 8'd0 || in_ready !== 1'b1 || out_s !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset got v=%b acc=%h cnt=%0d rdy=%b s=%h exp v=0 acc=00 cnt=0 rdy=1 s=00", out_valid, acc, op_count, in_ready, out_s);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost%0d got v=%b s=%h exp v=0", i, out_valid, out_s); end
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_backpressure();
      test_acc_chain();
      test_clear_idle();
      test_saturation();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, registered successor to the 1-bit, 8-function mux-based logic unit. It applies one of eight bitwise functions to two WIDTH-bit operands. Results pass through a one-cycle output stage with a valid/ready handshake and a skid register. An accumulator mode feeds each result back as operand A, which allows chained bitwise reductions. It sits between the operand-fetch logic and any result consumer in the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 8, width of the accepted-operation counter

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand/op presented this cycle
in_ready  output  1  block can accept this cycle
in_a  input  WIDTH  operand A (ignored when acc_mode=1)
in_b  input  WIDTH  operand B
op  input  3  function select
acc_mode  input  1  1: operand A := accumulator
acc_clear  input  1  zero the accumulator (see priority rules)
out_valid  output  1  out_s holds a result
out_ready  input  1  consumer takes result this cycle
out_s  output  WIDTH  result
acc  output  WIDTH  current accumulator value
op_count  output  CNT_W  accepted operations, saturating

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset (rst=1 at an edge): out_valid=0, out_s=0, skid empty, acc=0, op_count=0. in_ready=1 in the cycle after reset.
- Reset mid-operation: any pending results are discarded. The output and skid registers are cleared. Handshake inputs are ignored in that cycle.
- op encoding (bitwise over WIDTH): 0 ~A; 1 ~B; 2 A|B; 3 ~(A|B); 4 A&B; 5 ~(A&B); 6 A^B; 7 ~(A^B).
- Operand A selection: acc_clear=1 -> 0; else acc_mode=1 -> acc; else in_a.
- Accept condition: in_valid & in_ready. The result is computed combinationally from the current inputs and registered at the edge.
- Latency: 1 cycle. A result accepted at edge N is visible on out_s with out_valid=1 after edge N, provided the output stage is free.
- Output stage: a result transfers when out_valid & out_ready.
  - Main register empty, or draining this cycle: a new result goes to the main register.
  - Main register full and stalled (out_ready=0): a new result goes to the skid register.
  - When main drains and skid is valid, skid moves to main on the same edge. A simultaneous accept then lands in skid.
- in_ready = ~skid_valid, registered (no combinational path from out_ready). Maximum of 2 results in flight.
- Full-throughput requirement: with out_ready=1 held, one result per cycle with no bubbles.
- Accumulator:
  - On an accepted op with acc_mode=1: acc := result.
  - acc_clear=1 with no accepted acc_mode op: acc := 0.
  - acc_clear=1 with an accepted acc_mode op: operand A=0 and acc := result, so the clear applies before use.
  - acc_mode=0 ops never modify acc, except through acc_clear.
- op_count increments by 1 on each accept and saturates at 2^CNT_W-1 (no wrap).
- Ordering: results leave strictly in acceptance order. No result is dropped or duplicated under any in_valid/out_ready pattern.
- X on in_a or in_b when in_valid=0 must not propagate to any state.

Test Plan:
- Reset then function sweep: WIDTH=8, in_a=8'hF0, in_b=8'hCC, op 0..7, out_ready=1 -> out_s = 0F, 33, FC, 03, C0, 3F, 3C, C3, one per cycle, each 1 cycle after accept, no bubbles.
- Backpressure: out_ready=0 while feeding 3 ops (op=4, pairs AA/0F, 55/FF, FF/F0) -> in_ready drops after 2 accepts. out_s holds 0A. Raise out_ready -> 0A, 55, F0 emerge in order with no loss. The third op is accepted only after in_ready returns to 1.
- Accumulator chain: acc_clear=1 with acc_mode=1, op=2, in_b=8'h01 -> acc=01. Then op=2 with in_b 02, 04, 08 -> acc=0F. Then op=6 with in_b=8'hFF -> acc=F0 and out_s=F0. in_a is ignored throughout (drive 8'hAA).
- Clear without an op: acc=F0, acc_clear=1, in_valid=0 -> acc=00 next cycle, out_valid unchanged.
- Saturation: CNT_W=3, 10 accepted ops -> op_count reaches 7 and stays 7.
- Reset mid-stream: 2 results pending with out_ready=0, then assert rst for 1 cycle -> out_valid=0, acc=0, op_count=0, in_ready=1 the next cycle. The pending results never appear.
